// File: rtl/conv_mac_pipe_if.sv
// conv_mac_pipe_if: pixel-window input stream and result-pixel output stream
// for conv_mac_pipe.
//   din       : KDIM*KDIM taps, N_CH channels of CH_W bits per tap
//   in_valid  : din valid              in_ready  : engine accepts din
//   dout/sat  : result pixel and flags out_valid : dout/sat valid
//   out_ready : downstream accepts
// Modports: slave = the engine, master = the surrounding logic.
interface conv_mac_pipe_if #(
   parameter int CH_W = 4,
   parameter int N_CH = 3,
   parameter int KDIM = 3
);
   logic [KDIM*KDIM*N_CH*CH_W-1:0] din;
   logic                           in_valid;
   logic                           in_ready;
   logic [N_CH*CH_W-1:0]           dout;
   logic [N_CH-1:0]                sat;
   logic                           out_valid;
   logic                           out_ready;

   modport master (output din, in_valid, out_ready,
                   input  in_ready, dout, sat, out_valid);
   modport slave  (input  din, in_valid, out_ready,
                   output in_ready, dout, sat, out_valid);
endinterface

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: 3-stage pipelined KDIM x KDIM convolution with a
// double-buffered signed kernel and per-channel clamp to [0, 2^CH_W-1].
//   clk, rst : clock, synchronous active-high reset
//   io       : conv_mac_pipe_if.slave (din/in_valid/in_ready, dout/sat/
//              out_valid/out_ready)
//   k_we, k_idx, k_data : write one coefficient into the shadow bank
//   k_swap   : copy the shadow bank into the active bank
//   abs_mode : only when CONV_ABS_EN is defined; take the magnitude of the
//              shifted sum before clamping (carried with each sample)
// Optional feature macro: CONV_ABS_EN.
module conv_mac_pipe #(
   parameter int CH_W  = 4,
   parameter int N_CH  = 3,
   parameter int KDIM  = 3,
   parameter int KW    = 5,
   parameter int SHIFT = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   conv_mac_pipe_if.slave               io,
   input  logic                         k_we,
   input  logic [$clog2(KDIM*KDIM)-1:0] k_idx,
   input  logic signed [KW-1:0]         k_data,
   input  logic                         k_swap
`ifdef CONV_ABS_EN
   ,
   input  logic                         abs_mode
`endif
);

   localparam int unsigned T   = KDIM * KDIM;
   localparam int unsigned CTR = (T - 1) / 2;
   localparam int          PW  = CH_W + KW + 1;
   localparam int          SW  = PW + $clog2(KDIM*KDIM);
   localparam logic signed [SW-1:0] MAXV = SW'((1 << CH_W) - 1);

   // Kernel banks
   logic signed [KW-1:0] k_act [T];
   logic signed [KW-1:0] k_shd [T];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned t = 0; t < T; t++) begin
            k_act[t] <= (t == CTR) ? KW'(1) : '0;
            k_shd[t] <= (t == CTR) ? KW'(1) : '0;
         end
      end else begin
         // Both use the pre-edge shadow, so a same-edge write misses the swap.
         if (k_swap) k_act <= k_shd;
         if (k_we && (32'(k_idx) < T)) k_shd[k_idx] <= k_data;
      end
   end

   // Global advance
   logic                 out_valid_q;
   logic [N_CH*CH_W-1:0] dout_q;
   logic [N_CH-1:0]      sat_q;
   logic                 adv;

   assign adv          = !out_valid_q || io.out_ready;
   assign io.in_ready  = adv;
   assign io.out_valid = out_valid_q;
   assign io.dout      = dout_q;
   assign io.sat       = sat_q;

   // S1: per-tap, per-channel products against the active bank
   logic signed [PW-1:0] prod_d [N_CH][T];
   logic signed [PW-1:0] prod_q [N_CH][T];
   logic                 v1;

   always_comb begin
      for (int unsigned c = 0; c < N_CH; c++) begin
         for (int unsigned t = 0; t < T; t++) begin
            prod_d[c][t] = PW'($signed({1'b0, io.din[(t*N_CH + c)*CH_W +: CH_W]}))
                         * PW'(k_act[t]);
         end
      end
   end

   // S2: full-width sum per channel
   logic signed [SW-1:0] sum_d [N_CH];
   logic signed [SW-1:0] sum_q [N_CH];
   logic                 v2;

   always_comb begin
      for (int unsigned c = 0; c < N_CH; c++) begin
         sum_d[c] = '0;
         for (int unsigned t = 0; t < T; t++) begin
            sum_d[c] = sum_d[c] + SW'(prod_q[c][t]);
         end
      end
   end

`ifdef CONV_ABS_EN
   logic abs1_q, abs2_q;
`endif

   // S3: shift, optional magnitude, clamp
   logic signed [SW-1:0] shifted;
   logic signed [SW-1:0] mag;
   logic [N_CH*CH_W-1:0] dout_d;
   logic [N_CH-1:0]      sat_d;

   always_comb begin
      dout_d  = '0;
      sat_d   = '0;
      shifted = '0;
      mag     = '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         shifted = sum_q[c] >>> SHIFT;
`ifdef CONV_ABS_EN
         mag = (abs2_q && (shifted < 0)) ? -shifted : shifted;
`else
         mag = shifted;
`endif
         if (mag < 0) begin
            sat_d[c] = 1'b1;
         end else if (mag > MAXV) begin
            dout_d[c*CH_W +: CH_W] = '1;
            sat_d[c]               = 1'b1;
         end else begin
            dout_d[c*CH_W +: CH_W] = mag[CH_W-1:0];
         end
      end
   end

   // Control: valid bits travel with the data; all stages hold when !adv
   always_ff @(posedge clk) begin
      if (rst) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         out_valid_q <= 1'b0;
         dout_q      <= '0;
         sat_q       <= '0;
      end else if (adv) begin
         v1          <= io.in_valid;
         v2          <= v1;
         out_valid_q <= v2;
         // Bubbles leave the last result on dout
         if (v2) begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (adv) begin
         prod_q <= prod_d;
         sum_q  <= sum_d;
`ifdef CONV_ABS_EN
         abs1_q <= abs_mode;
         abs2_q <= abs1_q;
`endif
      end
   end

endmodule
